// File: rtl/controle_arrolhamento.sv
// Corking-station sequencer: belt motor, fill wait, one cork request per bottle,
// corker actuator timing, and saturating counts of corked bottles and reloads.
module controle_arrolhamento #(
    parameter int unsigned T_ARROLHA = 4,
    parameter int unsigned T_LIBERA  = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sensor_garrafa,
    input  logic             enchimento_ok,
    input  logic             rolha_disponivel,
    input  logic             disp_acionado,
    output logic             motor_esteira,
    output logic             atuador_rolha,
    output logic             dec_rolha,
    output logic             inicio_proc,
    output logic             alarme_sem_rolha,
    output logic [CNT_W-1:0] garrafas_ok,
    output logic [CNT_W-1:0] recargas,
    output logic [2:0]       estado
);

    typedef enum logic [2:0] {
        PARADO      = 3'd0,
        ESTEIRA     = 3'd1,
        ESPERA_ENCH = 3'd2,
        ARROLHA     = 3'd3,
        LIBERA      = 3'd4,
        SEM_ROLHA   = 3'd5
    } estado_t;

    // Cycle counter only needs to reach the larger of the two timing limits.
    localparam int unsigned CMAX = (T_ARROLHA > T_LIBERA) ? T_ARROLHA : T_LIBERA;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CMAX);
    localparam logic [CW-1:0] ARR_ULTIMO  = CW'(T_ARROLHA - 1);
    localparam logic [CW-1:0] LIB_MINIMO  = CW'(T_LIBERA - 1);

    estado_t          state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             dec_q, dec_d;
    logic             ini_q, ini_d;
    logic [CNT_W-1:0] ok_q, rec_q;
    logic             ok_inc;

    // Next-state, stop-pending and pulse decode; stop wins in every state.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ok_inc  = 1'b0;
        unique case (state_q)
            PARADO: begin
                if (start && !stop) state_d = ESTEIRA;
            end
            ESTEIRA: begin
                if (stop)                state_d = PARADO;
                else if (sensor_garrafa) state_d = ESPERA_ENCH;
            end
            ESPERA_ENCH: begin
                if (stop)                state_d = PARADO;
                else if (enchimento_ok)  state_d = rolha_disponivel ? ARROLHA : SEM_ROLHA;
            end
            ARROLHA: begin
                if (stop) pend_d = 1'b1;
                if (cnt_q == ARR_ULTIMO) begin
                    state_d = LIBERA;
                    ok_inc  = 1'b1;
                end
            end
            LIBERA: begin
                if (stop) pend_d = 1'b1;
                if (cnt_q >= LIB_MINIMO && !sensor_garrafa) begin
                    if (pend_q || stop) begin
                        state_d = PARADO;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ESTEIRA;
                    end
                end
            end
            SEM_ROLHA: begin
                if (stop)                  state_d = PARADO;
                else if (rolha_disponivel) state_d = ARROLHA;
            end
            default: state_d = PARADO;
        endcase

        dec_d = (state_d == ARROLHA) && (state_q != ARROLHA);
        ini_d = (state_q == PARADO) && (state_d == ESTEIRA);

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
        else                     cnt_d = cnt_q;
    end

    // State, timer, pending stop and entry pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PARADO;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            dec_q   <= 1'b0;
            ini_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dec_q   <= dec_d;
            ini_q   <= ini_d;
        end
    end

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_q  <= '0;
            rec_q <= '0;
        end else begin
            if (ok_inc && ok_q != '1)        ok_q  <= ok_q + CNT_W'(1);
            if (disp_acionado && rec_q != '1) rec_q <= rec_q + CNT_W'(1);
        end
    end

    // Moore decodes of the state register.
    always_comb begin
        motor_esteira    = (state_q == ESTEIRA) || (state_q == LIBERA);
        atuador_rolha    = (state_q == ARROLHA);
        alarme_sem_rolha = (state_q == SEM_ROLHA);
        estado           = state_q;
        dec_rolha        = dec_q;
        inicio_proc      = ini_q;
        garrafas_ok      = ok_q;
        recargas         = rec_q;
    end

endmodule
